// File: rtl/wb_scoreboard.sv
// wb_scoreboard: MEM/WB pipeline register with load extraction, register-file write port and pending-write scoreboard.
// Ports:
//   clk, rst            clock and asynchronous active-high reset
//   stall, flush        freeze MEM/WB (and suppress write) / squash the MEM instruction
//   mem_*               instruction presented by the MEM stage
//   iss_*               instruction issued from ID (scoreboard increment)
//   rs1, rs2 -> busy*   pending-write query for two source registers
//   RFWr, WBSel, WD     register-file write port
//   sb_err              sticky counter overflow/underflow flag
module wb_scoreboard (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        flush,
  input  logic        mem_valid,
  input  logic        mem_regwr,
  input  logic [4:0]  mem_rd,
  input  logic [1:0]  mem_wdsel,
  input  logic [31:0] mem_alu,
  input  logic [31:0] mem_rdata,
  input  logic [31:0] mem_pc4,
  input  logic [2:0]  mem_dmtype,
  input  logic [1:0]  mem_addr_lo,
  input  logic        iss_valid,
  input  logic        iss_regwr,
  input  logic [4:0]  iss_rd,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  output logic        busy1,
  output logic        busy2,
  output logic        RFWr,
  output logic [4:0]  WBSel,
  output logic [31:0] WD,
  output logic        sb_err
);
  logic        wb_valid, wb_regwr;
  logic [4:0]  wb_rd;
  logic [1:0]  wb_wdsel, wb_addr_lo;
  logic [31:0] wb_alu, wb_rdata, wb_pc4;
  logic [2:0]  wb_dmtype;
  logic [1:0]  cnt [32];
  logic [1:0]  nc [32];
  logic [3:0]  n [32];
  logic        err_n, iss_hit, sq_hit;
  logic [15:0] half;
  logic [7:0]  bt;
  logic [31:0] ld, wd_sel;
  always_comb begin
    half = wb_addr_lo[1] ? wb_rdata[31:16] : wb_rdata[15:0];
    bt = wb_rdata[{wb_addr_lo, 3'b000} +: 8];
    ld = wb_dmtype == 3'd1 ? {{16{half[15]}}, half} :
         wb_dmtype == 3'd2 ? {16'h0, half} :
         wb_dmtype == 3'd3 ? {{24{bt[7]}}, bt} :
         wb_dmtype == 3'd4 ? {24'h0, bt} : wb_rdata;
    wd_sel = wb_wdsel == 2'd0 ? wb_alu :
             wb_wdsel == 2'd1 ? ld :
             wb_wdsel == 2'd2 ? wb_pc4 : 32'h0;
  end
  assign RFWr   = wb_valid & wb_regwr & (wb_rd != 5'd0) & ~stall;
  assign WBSel  = RFWr ? wb_rd : 5'd0;
  assign WD     = RFWr ? wd_sel : 32'h0;
  assign iss_hit = iss_valid & iss_regwr & (iss_rd != 5'd0);
  assign sq_hit  = flush & mem_valid & mem_regwr & (mem_rd != 5'd0);
  assign busy1  = cnt[rs1] != 2'd0;
  assign busy2  = cnt[rs2] != 2'd0;
  // Counters are evaluated with a +2 offset so the net sum (-2..+4) stays unsigned; 2 means zero.
  always_comb begin
    err_n = 1'b0;
    for (int i = 0; i < 32; i++) begin
      n[i] = {2'b00, cnt[i]} + 4'd2 + {3'b000, iss_hit && iss_rd == 5'(i)}
           - {3'b000, RFWr && wb_rd == 5'(i)} - {3'b000, sq_hit && mem_rd == 5'(i)};
      err_n = err_n | (n[i] > 4'd5) | (n[i] < 4'd2);
      nc[i] = n[i] > 4'd5 ? 2'd3 : n[i] < 4'd2 ? 2'd0 : 2'(n[i] - 4'd2);
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wb_valid   <= 1'b0;
      wb_regwr   <= 1'b0;
      wb_rd      <= 5'd0;
      wb_wdsel   <= 2'd0;
      wb_alu     <= 32'h0;
      wb_rdata   <= 32'h0;
      wb_pc4     <= 32'h0;
      wb_dmtype  <= 3'd0;
      wb_addr_lo <= 2'd0;
      cnt        <= '{default: 2'd0};
      sb_err     <= 1'b0;
    end else begin
      if (flush) wb_valid <= 1'b0;
      else if (!stall) begin
        wb_valid   <= mem_valid;
        wb_regwr   <= mem_regwr;
        wb_rd      <= mem_rd;
        wb_wdsel   <= mem_wdsel;
        wb_alu     <= mem_alu;
        wb_rdata   <= mem_rdata;
        wb_pc4     <= mem_pc4;
        wb_dmtype  <= mem_dmtype;
        wb_addr_lo <= mem_addr_lo;
      end
      cnt    <= nc;
      sb_err <= sb_err | err_n;
    end
  end
endmodule

// File: tb/tb_wb_scoreboard.sv
// tb_wb_scoreboard: table-driven and sequence checks of wb_scoreboard with an expected-result queue.
module tb_wb_scoreboard;
  logic        clk = 1'b0, rst, stall, flush, mem_valid, mem_regwr, iss_valid, iss_regwr;
  logic [4:0]  mem_rd, iss_rd, rs1, rs2, WBSel;
  logic [1:0]  mem_wdsel, mem_addr_lo;
  logic [31:0] mem_alu, mem_rdata, mem_pc4, WD;
  logic [2:0]  mem_dmtype;
  logic        busy1, busy2, RFWr, sb_err;
  int checks = 0, errors = 0;
  wb_scoreboard dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush), .mem_valid(mem_valid),
    .mem_regwr(mem_regwr), .mem_rd(mem_rd), .mem_wdsel(mem_wdsel), .mem_alu(mem_alu),
    .mem_rdata(mem_rdata), .mem_pc4(mem_pc4), .mem_dmtype(mem_dmtype),
    .mem_addr_lo(mem_addr_lo), .iss_valid(iss_valid), .iss_regwr(iss_regwr),
    .iss_rd(iss_rd), .rs1(rs1), .rs2(rs2), .busy1(busy1), .busy2(busy2),
    .RFWr(RFWr), .WBSel(WBSel), .WD(WD), .sb_err(sb_err)
  );
  always #5 clk = ~clk;
  typedef struct {
    logic [1:0]  wdsel;
    logic [2:0]  dmtype;
    logic [1:0]  lo;
    logic        regwr;
    logic [4:0]  rd;
    logic        rfwr;
    logic [31:0] wd;
  } vec_t;
  typedef struct {
    logic        rfwr;
    logic [4:0]  sel;
    logic [31:0] wd;
  } exp_t;
  vec_t v[15];
  exp_t q[$];
  exp_t e;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  initial begin
    v[0]  = '{2'd0, 3'd0, 2'd0, 1'b1, 5'd5,  1'b1, 32'h12345678};
    v[1]  = '{2'd1, 3'd3, 2'd2, 1'b1, 5'd6,  1'b1, 32'hFFFFFFFF};
    v[2]  = '{2'd1, 3'd4, 2'd3, 1'b1, 5'd7,  1'b1, 32'h00000080};
    v[3]  = '{2'd1, 3'd1, 2'd2, 1'b1, 5'd8,  1'b1, 32'hFFFF80FF};
    v[4]  = '{2'd1, 3'd2, 2'd0, 1'b1, 5'd9,  1'b1, 32'h00007F01};
    v[5]  = '{2'd1, 3'd3, 2'd0, 1'b1, 5'd10, 1'b1, 32'h00000001};
    v[6]  = '{2'd1, 3'd3, 2'd1, 1'b1, 5'd11, 1'b1, 32'h0000007F};
    v[7]  = '{2'd1, 3'd0, 2'd2, 1'b1, 5'd12, 1'b1, 32'h80FF7F01};
    v[8]  = '{2'd1, 3'd5, 2'd1, 1'b1, 5'd13, 1'b1, 32'h80FF7F01};
    v[9]  = '{2'd1, 3'd1, 2'd1, 1'b1, 5'd14, 1'b1, 32'h00007F01};
    v[10] = '{2'd2, 3'd0, 2'd0, 1'b1, 5'd15, 1'b1, 32'h00001004};
    v[11] = '{2'd3, 3'd0, 2'd0, 1'b1, 5'd3,  1'b1, 32'h00000000};
    v[12] = '{2'd0, 3'd0, 2'd0, 1'b1, 5'd0,  1'b0, 32'h00000000};
    v[13] = '{2'd0, 3'd0, 2'd0, 1'b0, 5'd4,  1'b0, 32'h00000000};
    v[14] = '{2'd1, 3'd4, 2'd1, 1'b1, 5'd31, 1'b1, 32'h0000007F};
    rst = 1'b1; stall = 1'b0; flush = 1'b0;
    mem_valid = 1'b1; mem_regwr = 1'b1; mem_rd = 5'd5; mem_wdsel = 2'd0;
    mem_alu = 32'h12345678; mem_rdata = 32'h80FF7F01; mem_pc4 = 32'h00001004;
    mem_dmtype = 3'd0; mem_addr_lo = 2'd0;
    iss_valid = 1'b1; iss_regwr = 1'b1; iss_rd = 5'd5; rs1 = 5'd5; rs2 = 5'd5;
    tick; tick;
    chk("rst_rfwr", RFWr, 0); chk("rst_wbsel", WBSel, 0); chk("rst_wd", WD, 0);
    chk("rst_busy1", busy1, 0); chk("rst_busy2", busy2, 0); chk("rst_sberr", sb_err, 0);
    mem_valid = 1'b0; iss_valid = 1'b0; rst = 1'b0;
    tick;
    chk("post_rst_rfwr", RFWr, 0);
    for (int i = 0; i < 15; i++) begin
      mem_valid = 1'b1; mem_regwr = v[i].regwr; mem_rd = v[i].rd; mem_wdsel = v[i].wdsel;
      mem_dmtype = v[i].dmtype; mem_addr_lo = v[i].lo;
      iss_valid = 1'b1; iss_regwr = v[i].regwr; iss_rd = v[i].rd;
      q.push_back('{v[i].rfwr, v[i].rfwr ? v[i].rd : 5'd0, v[i].wd});
      tick;
      e = q.pop_front();
      chk($sformatf("vec%0d_rfwr", i), RFWr, e.rfwr);
      chk($sformatf("vec%0d_wbsel", i), WBSel, e.sel);
      chk($sformatf("vec%0d_wd", i), WD, e.wd);
    end
    mem_valid = 1'b0; iss_valid = 1'b0; rs1 = 5'd5; rs2 = 5'd31;
    tick;
    chk("drain_rfwr", RFWr, 0); chk("drain_busy1", busy1, 0);
    chk("drain_busy2", busy2, 0); chk("drain_sberr", sb_err, 0);
    // issue then write back rd=5
    iss_valid = 1'b1; iss_regwr = 1'b1; iss_rd = 5'd5;
    tick;
    iss_valid = 1'b0;
    chk("seqA_busy_issued", busy1, 1);
    mem_valid = 1'b1; mem_regwr = 1'b1; mem_rd = 5'd5; mem_wdsel = 2'd0; mem_alu = 32'h12345678;
    tick;
    mem_valid = 1'b0;
    chk("seqA_rfwr", RFWr, 1); chk("seqA_wbsel", WBSel, 5); chk("seqA_wd", WD, 32'h12345678);
    chk("seqA_busy_wb", busy1, 1);
    tick;
    chk("seqA_rfwr_after", RFWr, 0); chk("seqA_busy_after", busy1, 0);
    // stall holds the entry for three cycles
    rs2 = 5'd6;
    iss_valid = 1'b1; iss_rd = 5'd6;
    mem_valid = 1'b1; mem_rd = 5'd6; mem_alu = 32'hAAAA5555;
    tick;
    iss_valid = 1'b0; mem_valid = 1'b0; stall = 1'b1;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk($sformatf("seqB_stall%0d_rfwr", k), RFWr, 0);
      chk($sformatf("seqB_stall%0d_busy", k), busy2, 1);
      tick;
    end
    stall = 1'b0;
    #1;
    chk("seqB_rel_rfwr", RFWr, 1); chk("seqB_rel_wd", WD, 32'hAAAA5555);
    tick;
    chk("seqB_done_rfwr", RFWr, 0); chk("seqB_done_busy", busy2, 0);
    chk("seqB_sberr", sb_err, 0);
    // flush squashes rd=7, then rd=0 leaves counters alone
    rs1 = 5'd7; rs2 = 5'd8;
    iss_valid = 1'b1; iss_rd = 5'd7;
    tick;
    iss_valid = 1'b0;
    chk("seqC_busy7", busy1, 1);
    mem_valid = 1'b1; mem_rd = 5'd7; flush = 1'b1;
    tick;
    flush = 1'b0; mem_valid = 1'b0;
    chk("seqC_rfwr", RFWr, 0); chk("seqC_busy7_sq", busy1, 0); chk("seqC_sberr", sb_err, 0);
    iss_valid = 1'b1; iss_rd = 5'd8;
    tick;
    iss_valid = 1'b0;
    mem_valid = 1'b1; mem_rd = 5'd0; flush = 1'b1;
    tick;
    chk("seqC_rd0_busy8", busy2, 1); chk("seqC_rd0_sberr", sb_err, 0);
    mem_rd = 5'd8;
    tick;
    flush = 1'b0; mem_valid = 1'b0;
    chk("seqC_busy8_sq", busy2, 0); chk("seqC_sberr2", sb_err, 0);
    // overflow on rd=9, then asynchronous reset
    rs1 = 5'd9;
    iss_valid = 1'b1; iss_rd = 5'd9;
    tick; tick; tick;
    chk("seqD_3_sberr", sb_err, 0); chk("seqD_3_busy", busy1, 1);
    tick;
    iss_valid = 1'b0;
    chk("seqD_4_sberr", sb_err, 1);
    tick;
    chk("seqD_sticky", sb_err, 1); chk("seqD_busy_sat", busy1, 1);
    #2 rst = 1'b1;
    #1;
    chk("seqD_rst_sberr", sb_err, 0); chk("seqD_rst_busy", busy1, 0);
    tick;
    rst = 1'b0;
    tick;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/wb_scoreboard.md
WB_SCOREBOARD -- requirements
Module: wb_scoreboard

Interface
REQ-001 SHALL have port clk  input  1  system clock, all state updates on rising edge.
REQ-002 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-003 SHALL have port stall  input  1  freeze MEM/WB register, suppress write.
REQ-004 SHALL have port flush  input  1  squash instruction presented by MEM this cycle.
REQ-005 SHALL have port mem_valid  input  1  MEM stage holds an instruction.
REQ-006 SHALL have ports mem_regwr (input, 1) and mem_rd (input, 5)  destination write enable and index.
REQ-007 SHALL have port mem_wdsel  input  2  write-data source: 00 ALU, 01 load, 10 PC+4, 11 zero.
REQ-008 SHALL have ports mem_alu, mem_rdata, mem_pc4 (input, 32 each)  ALU result, raw memory word, PC+4.
REQ-009 SHALL have ports mem_dmtype (input, 3) and mem_addr_lo (input, 2)  load type (000 word, 001 half signed, 010 half unsigned, 011 byte signed, 100 byte unsigned, others word) and byte offset.
REQ-010 SHALL have ports iss_valid (input, 1), iss_regwr (input, 1), iss_rd (input, 5)  instruction issued from ID.
REQ-011 SHALL have ports rs1, rs2 (input, 5) and busy1, busy2 (output, 1)  scoreboard query: pending write to source.
REQ-012 SHALL have ports RFWr (output, 1), WBSel (output, 5), WD (output, 32)  register-file write port.
REQ-013 SHALL have port sb_err  output  1  sticky scoreboard overflow/underflow flag.

Function
REQ-014 SHALL hold a MEM/WB register (valid, regwr, rd, wdsel, alu, rdata, pc4, dmtype, addr_lo).
REQ-015 Register update priority: flush -> valid<=0; else stall -> hold; else capture all MEM inputs.
REQ-016 RFWr SHALL be combinational: wb_valid & wb_regwr & (wb_rd!=0) & !stall.
REQ-017 WBSel SHALL equal wb_rd when RFWr=1, else 0; WD SHALL equal selected data when RFWr=1, else 0.
REQ-018 Load extraction, little-endian: half uses bits [15:0] if addr_lo[1]=0 else [31:16]; byte uses lane addr_lo (00 -> [7:0] ... 11 -> [31:24]); signed types sign-extend, unsigned zero-extend to 32; addr_lo[0] ignored for half.
REQ-019 Write latency: an instruction captured at edge N drives RFWr during cycle N..N+1 (one cycle) unless stall is held; while stalled, no write occurs and the entry is retained.
REQ-020 Scoreboard: one 2-bit pending counter per register 1..31; register 0 never tracked, busy for index 0 always 0.
REQ-021 Per register per edge: +1 on issue (iss_valid & iss_regwr & iss_rd match & !=0); -1 on commit (RFWr & WBSel match); -1 on squash (flush & mem_valid & mem_regwr & mem_rd match).
REQ-022 Simultaneous events SHALL net-sum (e.g. issue and commit same register -> unchanged).
REQ-023 Result above 3 SHALL saturate at 3 and set sb_err; result below 0 SHALL clamp at 0 and set sb_err.
REQ-024 busy1/busy2 SHALL be combinational: counter[rsN] != 0, reflecting state before the current edge (no same-cycle commit bypass).
REQ-025 sb_err SHALL remain 1 until reset.

Reset
REQ-026 On rst=1, asynchronously: wb_valid=0, all MEM/WB fields=0, all counters=0, sb_err=0; hence RFWr=0, WBSel=0, WD=0, busy1=busy2=0.
REQ-027 Reset mid-operation SHALL discard in-flight entry without a write; first capture occurs on the first rising edge after rst deasserts.

Verification
REQ-028 Issue rd=5, then MEM presents rd=5, wdsel=00, alu=0x12345678 -> busy1(rs1=5)=1 until the WB cycle; RFWr=1, WBSel=5, WD=0x12345678 for one cycle; busy1=0 afterwards.
REQ-029 Load mem_rdata=0x80FF7F01, dmtype=011, addr_lo=10 -> WD=0xFFFFFFFF; dmtype=100, addr_lo=11 -> WD=0x00000080; dmtype=001, addr_lo=10 -> WD=0xFFFF80FF.
REQ-030 Entry in WB with stall=1 for 3 cycles -> RFWr=0 for 3 cycles, then one write on release; counter decremented exactly once.
REQ-031 flush with mem_valid=1, mem_rd=7, counter[7]=1 -> next cycle no write, busy(7)=0, sb_err=0; same with rd=0 -> no counter change.
REQ-032 Issue rd=9 four times without commit -> counter[9]=3, sb_err=1 and stays 1; assert rst -> sb_err=0, busy=0 immediately.
REQ-033 mem_rd=0 with mem_regwr=1 -> RFWr=0, WBSel=0, WD=0.
